// File: rtl/cpu1_key_pkg.sv
// rtl/cpu1_key_pkg.sv - shared FSM states, key PIO register map and defaults for cpu1_key_master
package cpu1_key_pkg;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_EDGE,
    CAP_EDGE,
    CLR_EDGE,
    RD_DATA,
    CAP_DATA,
    EMIT
  } key_state_t;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int DEFAULT_POLL_CYCLES = 50000;

  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/cpu1_key_poll_timer.sv
// rtl/cpu1_key_poll_timer.sv - free-running poll timer; each expiry latches a pending flag
// The flag survives until the master starts a service sequence, so a stalled consumer never loses a poll.
module cpu1_key_poll_timer
  import cpu1_key_pkg::*;
#(
  parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_pending
);

  localparam int TW = timer_width(POLL_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(POLL_CYCLES - 1);

  logic [TW-1:0] r_count;
  logic          r_pending;
  logic          w_expire;

  assign w_expire  = (r_count == LAST);
  assign o_pending = r_pending;

  // An expiry in the same cycle as a clear wins, so that poll is not dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_count   <= w_expire ? '0 : r_count + TW'(1);
      r_pending <= w_expire | (r_pending & ~i_clear);
    end
  end

endmodule

// File: rtl/cpu1_key_master.sv
// rtl/cpu1_key_master.sv - bus master servicing a key PIO slave and emitting key events
// Optional irq-driven service and INIT mask write: define CPU1_KEY_MASTER_IRQ_EN.
module cpu1_key_master
  import cpu1_key_pkg::*;
#(
  parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             irq_in,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic             evt_level,
  output logic [CNT_W-1:0] press_count
);

  key_state_t       r_state;
  logic             r_cs;
  logic             r_wn;
  logic [1:0]       r_addr;
  logic [31:0]      r_wd;
  logic             r_edge;
  logic             r_valid;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  logic w_pending;
  logic w_irq;
  logic w_start;
  logic w_unused;

`ifdef CPU1_KEY_MASTER_IRQ_EN
  localparam key_state_t RESET_STATE = INIT;
  assign w_irq    = irq_in;
  assign w_unused = ^avm_readdata[31:1];
`else
  localparam key_state_t RESET_STATE = IDLE;
  assign w_irq    = 1'b0;
  assign w_unused = ^{avm_readdata[31:1], irq_in};
`endif

  assign w_start = (r_state == IDLE) && enable && (w_pending || w_irq);

  cpu1_key_poll_timer #(
    .POLL_CYCLES(POLL_CYCLES)
  ) u_poll_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (w_start),
    .o_pending(w_pending)
  );

  assign avm_address    = r_addr;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_wn;
  assign avm_writedata  = r_wd;
  assign evt_valid      = r_valid;
  assign evt_level      = r_level;
  assign press_count    = r_cnt;

  // Bus strobes are registered on the transition into the state that owns them,
  // so each transfer is visible for exactly the one cycle that state lasts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RESET_STATE;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_addr  <= ADDR_DATA;
      r_wd    <= 32'd0;
      r_edge  <= 1'b0;
      r_valid <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_cs   <= 1'b0;
      r_wn   <= 1'b1;
      r_addr <= ADDR_DATA;
      r_wd   <= 32'd0;
      case (r_state)
        INIT: begin
          r_cs    <= 1'b1;
          r_wn    <= 1'b0;
          r_addr  <= ADDR_IRQ_MASK;
          r_wd    <= 32'd1;
          r_state <= IDLE;
        end
        IDLE: begin
          if (w_start) begin
            r_cs    <= 1'b1;
            r_addr  <= ADDR_EDGE_CAP;
            r_state <= RD_EDGE;
          end
        end
        RD_EDGE: r_state <= CAP_EDGE;
        CAP_EDGE: begin
          r_edge <= avm_readdata[0];
          r_cs   <= 1'b1;
          if (avm_readdata[0]) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_wn    <= 1'b0;
            r_addr  <= ADDR_EDGE_CAP;
            r_state <= CLR_EDGE;
          end else begin
            r_addr  <= ADDR_DATA;
            r_state <= RD_DATA;
          end
        end
        CLR_EDGE: begin
          r_cs    <= 1'b1;
          r_addr  <= ADDR_DATA;
          r_state <= RD_DATA;
        end
        RD_DATA: r_state <= CAP_DATA;
        CAP_DATA: begin
          if (r_edge) begin
            r_level <= avm_readdata[0];
            r_valid <= 1'b1;
            r_state <= EMIT;
          end else begin
            r_state <= IDLE;
          end
        end
        EMIT: begin
          if (evt_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
